axi_apb_xfer_fsm: RTL
=====================

Name: axi_apb_xfer_fsm

Overview:
Consumes single-beat AXI-lite requests from upstream axi_single_slice buffers (AW, W, AR) and runs one APB3 transfer per request. Returns B/R responses into downstream response slices. Sits between the AXI-side slices and the APB master port of the bridge. Handles one outstanding transfer at a time.

Parameters:
ADDR_WIDTH, 32, AXI/APB address width
DATA_WIDTH, 32, AXI/APB data width (no byte strobes, APB3)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
aw_valid_i  in  1  write-address slice valid
aw_ready_o  out  1  pop write-address slice
aw_data_i  in  ADDR_WIDTH  write address
w_valid_i  in  1  write-data slice valid
w_ready_o  out  1  pop write-data slice
w_data_i  in  DATA_WIDTH  write data
ar_valid_i  in  1  read-address slice valid
ar_ready_o  out  1  pop read-address slice
ar_data_i  in  ADDR_WIDTH  read address
b_valid_o  out  1  write response valid into B slice
b_ready_i  in  1  B slice not full
b_data_o  out  2  write response code
r_valid_o  out  1  read response valid into R slice
r_ready_i  in  1  R slice not full
r_data_o  out  DATA_WIDTH+2  {read data, response code}
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction, 1 = write
paddr_o  out  ADDR_WIDTH  APB address
pwdata_o  out  DATA_WIDTH  APB write data
pready_i  in  1  APB ready
prdata_i  in  DATA_WIDTH  APB read data
pslverr_i  in  1  APB slave error

Behaviour:
- Reset is asynchronous, active low. Reset state is IDLE. All outputs are 0 in reset. The arbitration priority bit resets to "read first".
- States are IDLE, SETUP, ACCESS, RESP. All APB and response outputs are registered.
- Write candidate: aw_valid_i & w_valid_i. Read candidate: ar_valid_i.
- IDLE, one candidate: accept it.
- IDLE, both candidates: accept the one the priority bit selects, then toggle the priority bit (round-robin).
- Accepting a write asserts aw_ready_o and w_ready_o together for exactly that cycle; both slices pop simultaneously.
- Accepting a read asserts ar_ready_o for that cycle.
- AW without W, or W without AW, is never accepted. Ready outputs are 0 outside IDLE.
- On accept, latch the address, the data (writes) and the direction. Next state is SETUP.
- SETUP lasts 1 cycle: psel=1, penable=0; paddr, pwrite and pwdata are valid. Next state is ACCESS.
- ACCESS: psel=1, penable=1, held until pready_i=1. There is no timeout; waits of any length are legal.
- On the pready cycle, capture resp = pslverr_i ? 2'b10 (SLVERR) : 2'b00 (OKAY). For reads, also capture prdata_i. Next state is RESP.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS. They return to 0 in IDLE.
- pready_i, prdata_i and pslverr_i are ignored outside ACCESS.
- RESP asserts b_valid_o (write) or r_valid_o (read), with data held stable until the matching ready_i=1. After that handshake cycle, go to IDLE.
- Valid must never drop before the handshake completes.
- Minimum latency, with pready=1 and the response slice ready:
  - cycle 0: accept in IDLE
  - cycle 1: SETUP
  - cycle 2: ACCESS
  - cycle 3: response valid
  - cycle 4: IDLE again
- Peak throughput is 1 transfer per 4 cycles.
- Reset mid-transfer drops the transfer: no response is produced and psel deasserts immediately (asynchronous).
- A read error still returns the captured prdata (slave-defined) with resp 2'b10.

Decomposition:
- Package axi_apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP)
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - resp_t (logic [1:0])
- No sub-module. Arbitration is a single priority flop, implemented inline.

Test Plan:
- Single write: addr 0x10, data 0xDEADBEEF, pready=1.
  - Required: aw/w pop on cycle 0; SETUP on cycle 1 with paddr=0x10, pwrite=1; ACCESS on cycle 2; b_valid with b_data=00 on cycle 3.
- Read with 3 wait states: addr 0x20, pready low for 3 ACCESS cycles, then prdata=0x12345678.
  - Required: penable held 4 cycles; r_data={0x12345678,00}.
- Simultaneous AW+W and AR valid after reset.
  - Required: read served first, then write.
  - With both still pending, the next arbitration picks the other type (alternation).
- AW valid with no W for 5 cycles, then W valid.
  - Required: no APB activity and aw_ready=0 until W arrives; then accepted.
- Write with pslverr=1 and b_ready low for 2 cycles.
  - Required: b_data=10 held stable with b_valid high for 3 cycles; IDLE after the handshake.
- rst_ni asserted during ACCESS of a read.
  - Required: psel/penable go to 0 asynchronously; no r_valid; the next request after reset starts cleanly in IDLE.

Source files
------------

// File: rtl/axi_apb_pkg.sv
// rtl/axi_apb_pkg.sv - shared types and response codes for the AXI-lite to APB transfer FSM
package axi_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_apb_xfer_fsm.sv
// rtl/axi_apb_xfer_fsm.sv - runs one APB3 transfer per accepted AXI-lite request, one outstanding at a time
module axi_apb_xfer_fsm
    import axi_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ADDR_WIDTH-1:0] aw_data_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_data_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [1:0]            b_data_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH+1:0] r_data_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    state_t                state, state_d;
    logic                  prio, prio_d;  // 0: read wins a tie, 1: write wins
    logic                  psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d;
    logic                  b_valid_d, r_valid_d;
    resp_t                 b_data_d, resp;
    logic [DATA_WIDTH+1:0] r_data_d;
    logic                  wr_cand, rd_cand, grant_wr, grant_rd;

    always_comb begin
        state_d   = state;
        prio_d    = prio;
        psel_d    = psel_o;
        penable_d = penable_o;
        pwrite_d  = pwrite_o;
        paddr_d   = paddr_o;
        pwdata_d  = pwdata_o;
        b_valid_d = b_valid_o;
        b_data_d  = b_data_o;
        r_valid_d = r_valid_o;
        r_data_d  = r_data_o;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        wr_cand   = aw_valid_i & w_valid_i;
        rd_cand   = ar_valid_i;
        resp      = pslverr_i ? RESP_SLVERR : RESP_OKAY;

        case (state)
            IDLE: begin
                if (rd_cand && (!wr_cand || !prio)) begin
                    grant_rd = 1'b1;
                end else if (wr_cand) begin
                    grant_wr = 1'b1;
                end
                if (rd_cand && wr_cand) begin
                    prio_d = ~prio;
                end
                if (grant_rd || grant_wr) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = grant_wr;
                    paddr_d   = grant_wr ? aw_data_i : ar_data_i;
                    pwdata_d  = grant_wr ? w_data_i : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d   = RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = '0;
                    pwdata_d  = '0;
                    if (pwrite_o) begin
                        b_valid_d = 1'b1;
                        b_data_d  = resp;
                    end else begin
                        r_valid_d = 1'b1;
                        r_data_d  = {prdata_i, resp};
                    end
                end
            end
            RESP: begin
                if ((b_valid_o && b_ready_i) || (r_valid_o && r_ready_i)) begin
                    state_d   = IDLE;
                    b_valid_d = 1'b0;
                    b_data_d  = RESP_OKAY;
                    r_valid_d = 1'b0;
                    r_data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pops are combinational so a slice is consumed in the accept cycle itself
    assign aw_ready_o = grant_wr & rst_ni;
    assign w_ready_o  = grant_wr & rst_ni;
    assign ar_ready_o = grant_rd & rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            prio      <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            b_valid_o <= 1'b0;
            b_data_o  <= RESP_OKAY;
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
        end else begin
            state     <= state_d;
            prio      <= prio_d;
            psel_o    <= psel_d;
            penable_o <= penable_d;
            pwrite_o  <= pwrite_d;
            paddr_o   <= paddr_d;
            pwdata_o  <= pwdata_d;
            b_valid_o <= b_valid_d;
            b_data_o  <= b_data_d;
            r_valid_o <= r_valid_d;
            r_data_o  <= r_data_d;
        end
    end

endmodule
